level_synth: RTL and testbench

Drives a registered output level from single-cycle edge-request pulses: the inverse of the edge-detecting monostable. Requests come in as rise, fall and toggle pulses, typically from monostable outputs or pattern logic. The block enforces programmable minimum high and minimum low hold times, and queues one pending request while a hold is in progress. It sits in the clock-generation path between request sources and pad/clock-output drivers.

---
 rtl/level_synth_pkg.sv | 29 ++
 rtl/hold_counter.sv | 25 ++
 rtl/level_synth.sv | 138 +++++++++++++
 tb/tb_level_synth.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/level_synth_pkg.sv
// Shared types and request decode for the level synthesizer.
// The decode collapses the rise/fall/toggle pulses into a single {valid, target} pair.
package level_synth_pkg;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } level_synth_state_e;

  typedef struct packed {
    logic valid;
    logic target;
  } level_req_t;

  // Toggle, or rise and fall together, both invert the effective level.
  function automatic level_req_t decode_req(input logic rise,
                                            input logic fall,
                                            input logic toggle,
                                            input logic eff_level);
    level_req_t r;
    r.valid = rise | fall | toggle;
    if (toggle || (rise && fall)) r.target = ~eff_level;
    else if (rise)                r.target = 1'b1;
    else                          r.target = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter for minimum hold times.
// A load takes priority over a decrement, and the count saturates at zero.
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the values that held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/level_synth.sv
// Registered level output driven by rise/fall/toggle pulses.
// Minimum high/low hold times are enforced, and one request is queued while a hold runs.
module level_synth
  import level_synth_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en_i,
  input  logic             drive_en_i,
  input  logic             rise_req_i,
  input  logic             fall_req_i,
  input  logic             toggle_req_i,
  input  logic [CNT_W-1:0] high_min_i,
  input  logic [CNT_W-1:0] low_min_i,
  output logic             level_o,
  output logic             busy_o,
  output logic             pending_o,
  output logic             drop_o
);

  level_synth_state_e state, state_nxt;
  level_req_t         req;
  logic               eff_level;
  logic               pend_tgt, pend_tgt_nxt;
  logic               level_nxt, drop_nxt;
  logic               apply, apply_tgt;
  logic               load, dec;
  logic [CNT_W-1:0]   load_val;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load & clk_en_i),
    .load_val (load_val),
    .dec      (dec & clk_en_i),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign eff_level = (state == HOLD_PEND) ? pend_tgt : level_o;
  assign req       = decode_req(rise_req_i, fall_req_i, toggle_req_i, eff_level);

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    level_nxt    = level_o;
    pend_tgt_nxt = pend_tgt;
    drop_nxt     = 1'b0;
    apply        = 1'b0;
    apply_tgt    = level_o;
    load         = 1'b0;
    load_val     = '0;
    dec          = 1'b0;

    if (!drive_en_i) begin
      state_nxt = READY;
      level_nxt = 1'b0;
      load      = 1'b1;
    end else begin
      unique case (state)
        READY: begin
          if (req.valid && req.target != level_o) begin
            apply     = 1'b1;
            apply_tgt = req.target;
          end
        end
        HOLD: begin
          // An expired hold behaves like READY, so a request on this edge applies at once.
          if (cnt_zero) begin
            if (req.valid && req.target != level_o) begin
              apply     = 1'b1;
              apply_tgt = req.target;
            end else begin
              state_nxt = READY;
            end
          end else begin
            dec = 1'b1;
            if (req.valid && req.target != level_o) begin
              pend_tgt_nxt = req.target;
              state_nxt    = HOLD_PEND;
            end
          end
        end
        HOLD_PEND: begin
          if (cnt_zero) begin
            apply     = 1'b1;
            apply_tgt = pend_tgt;
          end else begin
            dec = 1'b1;
            if (req.valid) begin
              if (req.target == level_o) begin
                state_nxt = HOLD;
                drop_nxt  = 1'b1;
              end else if (req.target != pend_tgt) begin
                pend_tgt_nxt = req.target;
                drop_nxt     = 1'b1;
              end
            end
          end
        end
        default: state_nxt = READY;
      endcase

      // The minimum for the new level is sampled only here, at the moment of change.
      if (apply) begin
        level_nxt = apply_tgt;
        load      = 1'b1;
        load_val  = apply_tgt ? high_min_i : low_min_i;
        state_nxt = (load_val != '0) ? HOLD : READY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= READY;
      level_o  <= 1'b0;
      pend_tgt <= 1'b0;
      drop_o   <= 1'b0;
    end else begin
      drop_o <= clk_en_i & drop_nxt;
      if (clk_en_i) begin
        state    <= state_nxt;
        level_o  <= level_nxt;
        pend_tgt <= pend_tgt_nxt;
      end
    end
  end

  assign busy_o    = (state != READY);
  assign pending_o = (state == HOLD_PEND);

endmodule

// File: tb/tb_level_synth.sv
// Directed bench for level_synth: a table of single-cycle vectors plus
// hand-written sequences for the drive-enable clear and the asynchronous reset.
module tb_level_synth;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en_i, drive_en_i, rise_req_i, fall_req_i, toggle_req_i;
  logic [7:0] high_min_i, low_min_i;
  logic       level_o, busy_o, pending_o, drop_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       ce, de, r, f, t;
    logic [7:0] hm, lm;
    logic       lvl, busy, pend, drop;
  } vec_t;

  vec_t vq[$];

  level_synth #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en_i     (clk_en_i),
    .drive_en_i   (drive_en_i),
    .rise_req_i   (rise_req_i),
    .fall_req_i   (fall_req_i),
    .toggle_req_i (toggle_req_i),
    .high_min_i   (high_min_i),
    .low_min_i    (low_min_i),
    .level_o      (level_o),
    .busy_o       (busy_o),
    .pending_o    (pending_o),
    .drop_o       (drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic l, input logic b,
                            input logic p, input logic d);
    check({tag, " level"},   level_o,   l);
    check({tag, " busy"},    busy_o,    b);
    check({tag, " pending"}, pending_o, p);
    check({tag, " drop"},    drop_o,    d);
  endtask

  function automatic void add(input logic ce, input logic de, input logic r,
                              input logic f, input logic t, input int hm, input int lm,
                              input logic l, input logic b, input logic p, input logic d);
    vec_t v;
    v.ce = ce; v.de = de; v.r = r; v.f = f; v.t = t;
    v.hm = 8'(hm); v.lm = 8'(lm);
    v.lvl = l; v.busy = b; v.pend = p; v.drop = d;
    vq.push_back(v);
  endfunction

  // Apply inputs just after an edge, let one rising edge pass, then sample.
  task automatic drive_cycle(input logic ce, input logic de, input logic r,
                             input logic f, input logic t, input logic [7:0] hm,
                             input logic [7:0] lm);
    clk_en_i = ce; drive_en_i = de;
    rise_req_i = r; fall_req_i = f; toggle_req_i = t;
    high_min_i = hm; low_min_i = lm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en_i = 1'b1; drive_en_i = 1'b1;
    rise_req_i = 1'b0; fall_req_i = 1'b0; toggle_req_i = 1'b0;
    high_min_i = '0; low_min_i = '0;

    // ce de r f t hm lm | level busy pend drop
    // rise at cycle 3 with zero minimum: no hold
    add(1,1,0,0,0, 0,0, 0,0,0,0);
    add(1,1,0,0,0, 0,0, 0,0,0,0);
    add(1,1,0,0,0, 0,0, 0,0,0,0);
    add(1,1,1,0,0, 0,0, 1,0,0,0);
    add(1,1,0,0,0, 0,0, 1,0,0,0);
    add(1,1,0,1,0, 0,0, 0,0,0,0);
    // high_min=3: fall queued, applied after edge 4
    add(1,1,1,0,0, 3,0, 1,1,0,0);
    add(1,1,0,1,0, 3,0, 1,1,1,0);
    add(1,1,0,0,0, 3,0, 1,1,1,0);
    add(1,1,0,0,0, 3,0, 1,1,1,0);
    add(1,1,0,0,0, 3,0, 0,0,0,0);
    // request on the cnt=0 edge applies immediately
    add(1,1,1,0,0, 1,0, 1,1,0,0);
    add(1,1,0,0,0, 1,0, 1,1,0,0);
    add(1,1,0,1,0, 1,0, 0,0,0,0);
    // low_min=5: rise queued, fall cancels it with a drop pulse
    add(1,1,1,0,0, 0,5, 1,0,0,0);
    add(1,1,0,1,0, 0,5, 0,1,0,0);
    add(1,1,1,0,0, 0,5, 0,1,1,0);
    add(1,1,0,1,0, 0,5, 0,1,0,1);
    add(1,1,0,0,0, 0,5, 0,1,0,0);
    add(1,1,0,0,0, 0,5, 0,1,0,0);
    add(1,1,0,0,0, 0,5, 0,1,0,0);
    add(1,1,0,0,0, 0,5, 0,0,0,0);
    // rise+fall and toggle invert; repeated rise is a no-op
    add(1,1,1,1,0, 0,0, 1,0,0,0);
    add(1,1,1,1,0, 0,0, 0,0,0,0);
    add(1,1,0,0,1, 0,0, 1,0,0,0);
    add(1,1,0,0,1, 0,0, 0,0,0,0);
    add(1,1,1,0,0, 0,0, 1,0,0,0);
    add(1,1,1,0,0, 0,0, 1,0,0,0);
    add(1,1,0,1,0, 0,0, 0,0,0,0);
    // high_min=2 with clk_en alternating; min changed mid-hold has no effect
    add(1,1,1,0,0, 2,0, 1,1,0,0);
    add(0,1,0,1,0, 0,0, 1,1,0,0);
    add(1,1,0,0,0, 0,0, 1,1,0,0);
    add(0,1,0,0,1, 0,0, 1,1,0,0);
    add(1,1,0,0,0, 0,0, 1,1,0,0);
    add(0,1,0,0,0, 0,0, 1,1,0,0);
    add(1,1,0,0,0, 0,0, 1,0,0,0);
    add(0,1,0,1,0, 0,0, 1,0,0,0);
    add(1,1,0,1,0, 0,0, 0,0,0,0);

    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive_cycle(vq[i].ce, vq[i].de, vq[i].r, vq[i].f, vq[i].t, vq[i].hm, vq[i].lm);
      check_outs($sformatf("vec%0d", i), vq[i].lvl, vq[i].busy, vq[i].pend, vq[i].drop);
    end

    // drive_en low during a hold with a queued request clears everything silently
    drive_cycle(1, 1, 1, 0, 0, 8'd4, 8'd0);
    check_outs("de_rise", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1, 1, 0, 1, 0, 8'd4, 8'd0);
    check_outs("de_pend", 1'b1, 1'b1, 1'b1, 1'b0);
    drive_cycle(1, 0, 0, 0, 0, 8'd4, 8'd0);
    check_outs("de_off", 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1, 1, 0, 0, 0, 8'd4, 8'd0);
    check_outs("de_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-hold, observed before the next clock edge
    drive_cycle(1, 1, 1, 0, 0, 8'd4, 8'd0);
    check_outs("ar_rise", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1, 1, 0, 1, 0, 8'd4, 8'd0);
    check_outs("ar_pend", 1'b1, 1'b1, 1'b1, 1'b0);
    fall_req_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("ar_async", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
